peak_tracker: RTL and testbench
===============================

# peak_tracker

Streaming 16-bit running max/min tracker that sits directly downstream of the `mag` magnitude comparator and consumes its `AgtB`/`AeqB`/`AltB` results. The block accepts a window of `WIN_LEN` unsigned samples over a valid/ready handshake. It reports the largest and smallest sample of the window, plus the index of each within the window, and pulses `done` when the window completes. Two `mag` instances are used: incoming sample vs. current max, and incoming sample vs. current min.

## Interface
- `WIN_LEN`, 8, samples per window; legal range 2..255
- `clk`  input  1  system clock, all state on rising edge
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low
- `start`  input  1  begin a new window; honoured only in IDLE
- `smp_vld`  input  1  `smp` holds a valid sample
- `smp`  input  16  unsigned sample
- `smp_rdy`  output  1  block accepts a sample this cycle
- `busy`  output  1  window in progress (ACC state)
- `done`  output  1  one-cycle pulse: window complete, results final
- `max_val`  output  16  largest sample of current/last window
- `min_val`  output  16  smallest sample of current/last window
- `max_idx`  output  8  window index (0-based) of `max_val`
- `min_idx`  output  8  window index (0-based) of `min_val`

## Operation
- Sample accepted on a rising edge when `smp_vld & smp_rdy`.
- FSM states: IDLE, ACC, DONE.
  - IDLE: `smp_rdy`=0. If `start`=1, clear `cnt`=0 and go to ACC.
  - ACC: `smp_rdy`=1, `busy`=1. On each accept, increment `cnt` (8-bit). If the accepted sample has `cnt==WIN_LEN-1`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- Update rules on accept:
  - `cnt==0`: `max_val`=`min_val`=`smp`; `max_idx`=`min_idx`=0.
  - `cnt>0`, max: `max_val`/`max_idx` update to `smp`/`cnt` only if `mag(smp, max_val).AgtB`.
  - `cnt>0`, min: `min_val`/`min_idx` update to `smp`/`cnt` only if `mag(smp, min_val).AltB`.
  - Ties (`AeqB`) never update, so the first occurrence is retained.
- Comparison is unsigned. 0xFFFF > 0x7FFF.
- `start` in ACC or DONE is ignored and has no side effects.
- `smp_vld` in IDLE or DONE is ignored; no sample is consumed.
- Results hold after DONE through IDLE until the first sample of the next window overwrites them.
- No arithmetic other than the `cnt` increment. `cnt` never exceeds `WIN_LEN-1`, so it does not wrap.

## Timing
- Reset values: IDLE state, `cnt`=0, `smp_rdy`=0, `busy`=0, `done`=0, `max_val`=`min_val`=0x0000, `max_idx`=`min_idx`=0.
- `start` sampled at edge N puts the block in ACC; `smp_rdy`=1 from cycle N+1.
- Compare and update happen in the same edge as the accept. Updated `max_*`/`min_*` are visible the cycle after the accept.
- The last sample is accepted at edge M. `done`=1 and `busy`=0 during cycle M+1, with results final. The block is back in IDLE at cycle M+2.
- Minimum window time is `WIN_LEN`+2 cycles from `start` to IDLE. Gaps in `smp_vld` stretch ACC with no other effect.
- `smp_rdy`, `busy`, and `done` are Moore outputs decoded from the state register only.
- Asserting `rst_n` low at any time aborts the window and forces all reset values immediately. This holds mid-window and during DONE; `done` drops asynchronously.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs at reset values, and `smp_rdy`=0 even with `smp_vld`=1.
- Basic window, `WIN_LEN`=8, back-to-back samples 0x0010, 0x8000, 0x0003, 0xFFFF, 0x0000, 0x7FFF, 0x0003, 0x1234 -> `max_val`=0xFFFF, `max_idx`=3, `min_val`=0x0000, `min_idx`=4. `done` is high exactly one cycle, the cycle after the 8th accept.
- Ties: 8 samples all 0x00AA -> `max_val`=`min_val`=0x00AA and both indices 0. Then 0x0005, 0x0009, 0x0009, 0x0005, … -> `max_idx`=1, `min_idx`=0.
- Handshake gaps: same data as the basic window with `smp_vld` low every other cycle -> identical results, `done` the cycle after the 8th accept. `smp_vld`=1 with `smp`=0xFFFF while in IDLE -> not consumed, results unchanged.
- Reset mid-window: assert `rst_n` low after 3 accepts -> outputs are reset values immediately. Then `start` plus 8 samples -> correct results with indices from 0.
- Ignored `start`: pulse `start` during ACC (after accept 4) and during the DONE cycle -> window still ends after 8 accepts, no extra window begins, and the block rests in IDLE with `smp_rdy`=0.

Source files
------------

// File: rtl/peak_tracker.sv
// -----------------------------------------------------------------------------
// peak_tracker
//   Streaming running max/min tracker over a window of WIN_LEN unsigned 16-bit
//   samples. Each accepted sample is compared against the current max and the
//   current min by two mag comparators. The value and 0-based window index of
//   the extremes are kept, and done pulses for one cycle when the window ends.
//
//   Ports
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     start    : begin a window (only honoured in IDLE)
//     smp_vld  : smp carries a valid sample
//     smp      : 16-bit unsigned sample
//     smp_rdy  : block accepts a sample this cycle (ACC)
//     busy     : window in progress (ACC)
//     done     : one-cycle pulse, results final (DONE)
//     max_val  : largest sample of current/last window
//     min_val  : smallest sample of current/last window
//     max_idx  : window index of max_val
//     min_idx  : window index of min_val
//
//   mag
//     Unsigned magnitude comparator producing one-hot AgtB/AeqB/AltB.
//     Built as an MSB-first cascade: the first differing bit decides.
// -----------------------------------------------------------------------------

module mag #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         AgtB,
    output logic         AeqB,
    output logic         AltB
);

    // gt_c[i] / eq_c[i]: relation of a[W-1:i] vs b[W-1:i]
    logic [W:0] gt_c;
    logic [W:0] eq_c;

    assign gt_c[W] = 1'b0;
    assign eq_c[W] = 1'b1;

    for (genvar i = W - 1; i >= 0; i--) begin : g_bit
        assign gt_c[i] = gt_c[i+1] | (eq_c[i+1] & a[i] & ~b[i]);
        assign eq_c[i] = eq_c[i+1] & ~(a[i] ^ b[i]);
    end

    assign AgtB = gt_c[0];
    assign AeqB = eq_c[0];
    assign AltB = ~gt_c[0] & ~eq_c[0];

endmodule

module peak_tracker #(
    parameter int WIN_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        smp_vld,
    input  logic [15:0] smp,
    output logic        smp_rdy,
    output logic        busy,
    output logic        done,
    output logic [15:0] max_val,
    output logic [15:0] min_val,
    output logic [7:0]  max_idx,
    output logic [7:0]  min_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(WIN_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;

    logic accept;
    logic first;
    logic last;

    logic max_gt, max_eq, max_lt;
    logic min_gt, min_eq, min_lt;
    logic upd_max;
    logic upd_min;

    // ------------------------------------------------------------------
    // Comparators: incoming sample vs. current max and current min
    // ------------------------------------------------------------------
    mag #(.W(16)) u_mag_max (
        .a    (smp),
        .b    (max_val),
        .AgtB (max_gt),
        .AeqB (max_eq),
        .AltB (max_lt)
    );

    mag #(.W(16)) u_mag_min (
        .a    (smp),
        .b    (min_val),
        .AgtB (min_gt),
        .AeqB (min_eq),
        .AltB (min_lt)
    );

    assign accept = (state == ACC) && smp_vld;
    assign first  = (cnt == 8'd0);
    assign last   = (cnt == LAST);

    // Strictly greater / strictly less only: a tie keeps the first occurrence.
    // The full one-hot result is qualified so only a clean strict ordering
    // moves an extreme.
    assign upd_max = max_gt & ~max_eq & ~max_lt;
    assign upd_min = min_lt & ~min_eq & ~min_gt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        smp_rdy = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ACC: begin
                smp_rdy = 1'b1;
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample counter. Cleared on the last accept so it never passes
    // WIN_LEN-1; start in IDLE clears it again regardless.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == IDLE && start) begin
            cnt <= 8'd0;
        end else if (accept) begin
            cnt <= last ? 8'd0 : cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Extremes. The first sample of a window seeds both; after that each
    // side moves only on a strict comparison. Results hold until the
    // next window's first accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= 16'h0000;
            min_val <= 16'h0000;
            max_idx <= 8'd0;
            min_idx <= 8'd0;
        end else if (accept) begin
            if (first) begin
                max_val <= smp;
                min_val <= smp;
                max_idx <= 8'd0;
                min_idx <= 8'd0;
            end else begin
                if (upd_max) begin
                    max_val <= smp;
                    max_idx <= cnt;
                end
                if (upd_min) begin
                    min_val <= smp;
                    min_idx <= cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_peak_tracker.sv
module tb_peak_tracker;

    typedef logic [15:0] win_t [8];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        smp_vld;
    logic [15:0] smp;
    logic        smp_rdy;
    logic        busy;
    logic        done;
    logic [15:0] max_val;
    logic [15:0] min_val;
    logic [7:0]  max_idx;
    logic [7:0]  min_idx;

    int total;
    int bad;

    // results recorded by drive_window
    int   dw_done_early;
    logic dw_rdy_first;
    logic dw_busy_first;
    logic dw_done_end;
    logic dw_busy_end;
    logic dw_done_after;
    logic dw_rdy_after;
    logic dw_busy_after;
    logic dw_rdy_after2;
    logic dw_timeout;

    peak_tracker #(.WIN_LEN(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .smp_vld (smp_vld),
        .smp     (smp),
        .smp_rdy (smp_rdy),
        .busy    (busy),
        .done    (done),
        .max_val (max_val),
        .min_val (min_val),
        .max_idx (max_idx),
        .min_idx (min_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs/outputs settled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs start + 8 accepts and the DONE/IDLE cycles after; records
    // handshake observations for the calling test to judge.
    task automatic drive_window(input win_t d, input bit gaps,
                                input bit start_at4, input bit start_in_done);
        int  i;
        int  cyc;
        bit  pulsed;
        logic rdy;
        i = 0;
        cyc = 0;
        pulsed = 0;
        dw_done_early = 0;
        dw_timeout = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        dw_rdy_first  = smp_rdy;
        dw_busy_first = busy;
        while (i < 8 && cyc < 100) begin
            smp_vld = gaps ? ((cyc % 2) == 1) : 1'b1;
            smp     = d[i];
            if (start_at4 && i == 4 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            rdy = smp_rdy;
            if (done) dw_done_early++;
            step();
            if (smp_vld && rdy) i++;
            cyc++;
        end
        smp_vld = 1'b0;
        start   = 1'b0;
        if (i < 8) dw_timeout = 1'b1;
        dw_done_end = done;
        dw_busy_end = busy;
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        dw_done_after = done;
        dw_rdy_after  = smp_rdy;
        dw_busy_after = busy;
        step();
        dw_rdy_after2 = smp_rdy;
    endtask

    task automatic check_results(input string tag,
                                 input logic [15:0] emax, input logic [7:0] emaxi,
                                 input logic [15:0] emin, input logic [7:0] emini);
        // thin wrapper would be a shared helper; tests compare inline instead
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start   = 1'($urandom_range(0, 1));
            smp_vld = 1'b1;
            smp     = 16'($urandom);
            @(negedge clk);
            total++;
            if (smp_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctl: rdy=%b busy=%b done=%b required 0 0 0", smp_rdy, busy, done);
            end
        end
        total++;
        if (max_val !== 16'h0 || min_val !== 16'h0 || max_idx !== 8'd0 || min_idx !== 8'd0) begin
            bad++;
            $display("FAIL reset_data: max=%h/%0d min=%h/%0d required 0000/0 0000/0",
                     max_val, max_idx, min_val, min_idx);
        end
        start   = 1'b0;
        smp_vld = 1'b0;
        smp     = 16'h0;
        rst_n   = 1'b1;
        step();
        total++;
        if (smp_rdy !== 1'b0 || max_val !== 16'h0) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b max=%h required 0 0000", smp_rdy, max_val);
        end
    endtask

    task automatic test_basic();
        win_t d = '{16'h0010, 16'h8000, 16'h0003, 16'hFFFF,
                    16'h0000, 16'h7FFF, 16'h0003, 16'h1234};
        drive_window(d, 0, 0, 0);
        total++;
        if (dw_rdy_first !== 1'b1 || dw_busy_first !== 1'b1) begin
            bad++;
            $display("FAIL basic_acc_entry: rdy=%b busy=%b required 1 1", dw_rdy_first, dw_busy_first);
        end
        total++;
        if (dw_timeout || dw_done_early != 0 || dw_done_end !== 1'b1 || dw_busy_end !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: timeout=%b early=%0d done=%b busy=%b required 0 0 1 0",
                     dw_timeout, dw_done_early, dw_done_end, dw_busy_end);
        end
        total++;
        if (dw_done_after !== 1'b0 || dw_rdy_after !== 1'b0 || dw_busy_after !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: done=%b rdy=%b busy=%b required 0 0 0",
                     dw_done_after, dw_rdy_after, dw_busy_after);
        end
        total++;
        if (max_val !== 16'hFFFF || max_idx !== 8'd3 || min_val !== 16'h0000 || min_idx !== 8'd4) begin
            bad++;
            $display("FAIL basic_result: max=%h/%0d min=%h/%0d required ffff/3 0000/4",
                     max_val, max_idx, min_val, min_idx);
        end
    endtask

    task automatic test_ties();
        win_t a = '{default: 16'h00AA};
        win_t b = '{16'h0005, 16'h0009, 16'h0009, 16'h0005,
                    16'h0007, 16'h0006, 16'h0008, 16'h0005};
        drive_window(a, 0, 0, 0);
        total++;
        if (max_val !== 16'h00AA || min_val !== 16'h00AA || max_idx !== 8'd0 || min_idx !== 8'd0) begin
            bad++;
            $display("FAIL ties_equal: max=%h/%0d min=%h/%0d required 00aa/0 00aa/0",
                     max_val, max_idx, min_val, min_idx);
        end
        drive_window(b, 0, 0, 0);
        total++;
        if (max_val !== 16'h0009 || max_idx !== 8'd1 || min_val !== 16'h0005 || min_idx !== 8'd0) begin
            bad++;
            $display("FAIL ties_first: max=%h/%0d min=%h/%0d required 0009/1 0005/0",
                     max_val, max_idx, min_val, min_idx);
        end
    endtask

    task automatic test_gaps();
        win_t d = '{16'h0010, 16'h8000, 16'h0003, 16'hFFFF,
                    16'h0000, 16'h7FFF, 16'h0003, 16'h1234};
        win_t t = '{16'h0005, 16'h0009, 16'h0009, 16'h0005,
                    16'h0007, 16'h0006, 16'h0008, 16'h0005};
        drive_window(d, 1, 0, 0);
        total++;
        if (dw_timeout || dw_done_early != 0 || dw_done_end !== 1'b1 || dw_done_after !== 1'b0) begin
            bad++;
            $display("FAIL gaps_done: timeout=%b early=%0d done=%b after=%b required 0 0 1 0",
                     dw_timeout, dw_done_early, dw_done_end, dw_done_after);
        end
        total++;
        if (max_val !== 16'hFFFF || max_idx !== 8'd3 || min_val !== 16'h0000 || min_idx !== 8'd4) begin
            bad++;
            $display("FAIL gaps_result: max=%h/%0d min=%h/%0d required ffff/3 0000/4",
                     max_val, max_idx, min_val, min_idx);
        end
        // small-valued window so a sample leaking in from IDLE would show
        drive_window(t, 0, 0, 0);
        smp_vld = 1'b1;
        smp     = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (smp_rdy !== 1'b0) begin
                bad++;
                $display("FAIL idle_rdy: rdy=%b required 0", smp_rdy);
            end
        end
        smp_vld = 1'b0;
        total++;
        if (max_val !== 16'h0009 || max_idx !== 8'd1 || min_val !== 16'h0005 || min_idx !== 8'd0) begin
            bad++;
            $display("FAIL idle_ignore: max=%h/%0d min=%h/%0d required 0009/1 0005/0",
                     max_val, max_idx, min_val, min_idx);
        end
    endtask

    task automatic test_reset_mid();
        win_t d = '{16'h0010, 16'h8000, 16'h0003, 16'hFFFF,
                    16'h0000, 16'h7FFF, 16'h0003, 16'h1234};
        start = 1'b1;
        step();
        start   = 1'b0;
        smp_vld = 1'b1;
        smp = 16'h1111; step();
        smp = 16'h4444; step();
        smp = 16'h2222; step();
        smp_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || smp_rdy !== 1'b0 || done !== 1'b0 ||
            max_val !== 16'h0 || min_val !== 16'h0 || max_idx !== 8'd0 || min_idx !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid: busy=%b rdy=%b done=%b max=%h/%0d min=%h/%0d required all 0",
                     busy, smp_rdy, done, max_val, max_idx, min_val, min_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_window(d, 0, 0, 0);
        total++;
        if (dw_timeout || dw_done_end !== 1'b1 ||
            max_val !== 16'hFFFF || max_idx !== 8'd3 || min_val !== 16'h0000 || min_idx !== 8'd4) begin
            bad++;
            $display("FAIL rst_mid_rerun: done=%b max=%h/%0d min=%h/%0d required 1 ffff/3 0000/4",
                     dw_done_end, max_val, max_idx, min_val, min_idx);
        end
        // reset during DONE drops done asynchronously
        drive_window(d, 0, 0, 0);
        start = 1'b1;
        step();
        start   = 1'b0;
        smp_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp = d[k];
            step();
        end
        smp_vld = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL rst_done_pre: done=%b required 1", done);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || max_val !== 16'h0) begin
            bad++;
            $display("FAIL rst_done: done=%b max=%h required 0 0000", done, max_val);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ignored_start();
        win_t d = '{16'h0010, 16'h8000, 16'h0003, 16'hFFFF,
                    16'h0000, 16'h7FFF, 16'h0003, 16'h1234};
        drive_window(d, 0, 1, 1);
        total++;
        if (dw_timeout || dw_done_early != 0 || dw_done_end !== 1'b1) begin
            bad++;
            $display("FAIL istart_done: timeout=%b early=%0d done=%b required 0 0 1",
                     dw_timeout, dw_done_early, dw_done_end);
        end
        total++;
        if (dw_rdy_after !== 1'b0 || dw_busy_after !== 1'b0 || dw_rdy_after2 !== 1'b0) begin
            bad++;
            $display("FAIL istart_idle: rdy=%b busy=%b rdy2=%b required 0 0 0",
                     dw_rdy_after, dw_busy_after, dw_rdy_after2);
        end
        total++;
        if (max_val !== 16'hFFFF || max_idx !== 8'd3 || min_val !== 16'h0000 || min_idx !== 8'd4) begin
            bad++;
            $display("FAIL istart_result: max=%h/%0d min=%h/%0d required ffff/3 0000/4",
                     max_val, max_idx, min_val, min_idx);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        smp_vld = 1'b0;
        smp     = 16'h0;
        test_reset();
        test_basic();
        test_ties();
        test_gaps();
        test_reset_mid();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
